// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI byte transmitter among NUM_REQ requesters.
// Optional WAIT_DONE abort timer enabled by defining SPI_TX_TIMEOUT_EN.
module spi_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16384,
  parameter int unsigned TIMEOUT_BITS   = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   spi_start,
  output logic [7:0]             spi_data,
  input  logic                   spi_done,
  output logic                   busy,
  output logic [7:0]             byte_count,
  output logic                   timeout_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } state_t;

  // Reject configurations the pointer or timeout counter cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 ||
      64'(TIMEOUT_CYCLES) > (64'(1) << TIMEOUT_BITS)) begin : g_bad_cfg
    $error("spi_tx_arbiter: unsupported parameter combination");
  end

  state_t               state, state_d;
  logic [PTR_W-1:0]     ptr, ptr_d;
  logic [PTR_W-1:0]     sel;
  logic                 found;
  logic [7:0]           sel_byte;
  logic [NUM_REQ-1:0]   grant_d, ack_d;
  logic                 spi_start_d, busy_d, timeout_err_d;
  logic [7:0]           spi_data_d, byte_count_d;

`ifdef SPI_TX_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] TMO_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_BITS-1:0] tmo_cnt, tmo_cnt_d;
`endif

  // First pending requester after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    sel   = ptr;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx  = (32'(ptr) + off) % NUM_REQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == sel) sel_byte = req_data[8*i +: 8];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    grant_d       = grant;
    ack_d         = '0;
    spi_start_d   = 1'b0;
    spi_data_d    = spi_data;
    byte_count_d  = byte_count;
    timeout_err_d = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_d     = LAUNCH;
          ptr_d       = sel;
          grant_d     = NUM_REQ'(1) << sel;
          spi_data_d  = sel_byte;
          spi_start_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
`ifdef SPI_TX_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        if (spi_done) begin
          state_d      = ACK;
          ack_d        = grant;
          byte_count_d = byte_count + 8'd1;
        end
`ifdef SPI_TX_TIMEOUT_EN
        else if (tmo_cnt == TMO_LIMIT) begin
          state_d       = IDLE;
          grant_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + TIMEOUT_BITS'(1);
        end
`endif
      end
      ACK: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= PTR_W'(NUM_REQ - 1);
      grant       <= '0;
      ack         <= '0;
      spi_start   <= 1'b0;
      spi_data    <= 8'h00;
      busy        <= 1'b0;
      byte_count  <= 8'h00;
      timeout_err <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      grant       <= grant_d;
      ack         <= ack_d;
      spi_start   <= spi_start_d;
      spi_data    <= spi_data_d;
      busy        <= busy_d;
      byte_count  <= byte_count_d;
      timeout_err <= timeout_err_d;
`ifdef SPI_TX_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares the single SPI byte transmitter (start/data/done interface, one byte per transaction) among NUM_REQ requesters, e.g. several GCD/memory-reader engines each producing result bytes.
- Round-robin arbitration, one byte per grant.
- Sits between the requester engines and the spi instance; sequences start pulses and returns a per-requester acknowledge when the byte has been shifted out.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 16384, cycles to wait for spi_done before abort (used only with SPI_TX_TIMEOUT_EN)
TIMEOUT_BITS, 15, counter width for TIMEOUT_CYCLES (must hold TIMEOUT_CYCLES)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; held high with data stable until ack
req_data  input  8*NUM_REQ  byte from requester i on req_data[8*i +: 8]
grant  output  NUM_REQ  one-hot, high for the granted requester for the whole transaction
ack  output  NUM_REQ  one-cycle pulse to the granted requester when its byte completes
spi_start  output  1  one-cycle start pulse to the SPI transmitter
spi_data  output  8  latched byte presented to the SPI transmitter, stable from LAUNCH through ACK
spi_done  input  1  one-cycle pulse from the SPI transmitter at end of byte
busy  output  1  high in every state except IDLE
byte_count  output  8  count of completed (acked) bytes, wraps 255 -> 0
timeout_err  output  1  one-cycle pulse on transaction abort (tied 0 without SPI_TX_TIMEOUT_EN)

Behaviour:
- All outputs registered.
- Reset values: state IDLE; grant 0; ack 0; spi_start 0; spi_data 0; busy 0; byte_count 0; timeout_err 0; RR pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: the cycle after reset, all outputs are at reset values and any in-flight ack is lost. The SPI unit shares the same reset.
- States: IDLE, LAUNCH, WAIT_DONE, ACK.
- IDLE:
  - If any req bit is high, select the first set bit searching from pointer+1 upward, modulo NUM_REQ.
  - Next cycle: grant = onehot(sel), spi_data = req_data[sel], pointer = sel, state LAUNCH.
  - If no req, stay in IDLE.
  - spi_done in IDLE is ignored.
- LAUNCH: spi_start = 1 for exactly this cycle; next state WAIT_DONE.
- WAIT_DONE:
  - Stay until spi_done = 1.
  - On spi_done, next cycle enters ACK.
  - spi_done coincident with the LAUNCH cycle is ignored; the transmitter cannot finish that fast.
- ACK:
  - ack[sel] = 1 for this one cycle; byte_count increments.
  - Next state IDLE; grant clears on leaving ACK.
- Latency: req rises in cycle 0 -> grant and spi_data valid in cycle 1 (LAUNCH, spi_start high) -> spi_done at cycle k -> ack in cycle k+1 -> next arbitration decision in cycle k+2 (IDLE).
- req deasserted while granted: the transaction still completes and ack is still pulsed; there is no cancel.
- Requester keeps req high after ack: it is re-eligible, but the pointer rotation gives every other pending requester one byte first.
- Multiple simultaneous req: exactly one grant bit is high; fairness is strict round robin.
- req_data changes after the IDLE sample have no effect; the byte is latched.
- byte_count wraps 255 -> 0 with no flag.

Optional Feature:
- Macro: SPI_TX_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_BITS-wide counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without spi_done, next cycle: timeout_err = 1 for one cycle, no ack, byte_count unchanged, grant cleared, state IDLE, pointer advanced past the failed requester.
  - spi_done in the same cycle as the limit wins: normal ACK, no error.
- Not defined: no counter; WAIT_DONE waits indefinitely; timeout_err constant 0.

Test Plan:
- Single request: NUM_REQ=4, req=0001, req_data[7:0]=8'h2A, spi_done 10 cycles after spi_start -> grant=0001 in cycle 1, spi_start one pulse in cycle 1, spi_data=8'h2A, ack=0001 one cycle after done, byte_count=1, busy low afterwards.
- Round robin: req=1111 held high, distinct bytes 8'h11/22/33/44 -> grant order 0,1,2,3,0; spi_data sequence 11,22,33,44,11; exactly one grant bit high at any time.
- Pointer fairness: req=0101 held high -> grants alternate 0,2,0,2; requester 1 and 3 never granted.
- Data latch and drop: req=0010 with data 8'h5C; after grant, change data to 8'hFF and drop req -> spi_data stays 8'h5C, ack[1] still pulses once.
- Reset mid-op: assert reset during WAIT_DONE -> next cycle grant=0, spi_start=0, busy=0, byte_count=0, no ack; then req=1000 -> requester 3 is granted first.
- Timeout (SPI_TX_TIMEOUT_EN, TIMEOUT_CYCLES=8): never pulse spi_done -> timeout_err pulse 8 cycles after entering WAIT_DONE, no ack, byte_count unchanged, next pending requester granted. Without the macro -> busy stays high indefinitely.
